// File: rtl/spio_pkg.sv
// spio_pkg: shared FSM state encoding and P_Data field offsets for the serial LED chain block.
// Contents: spio_state_t (refresh sequencer states), CS_LSB / LED_LSB field offsets,
//           gpio_lsb() giving the GPIO field offset for a given LED image width.
package spio_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DONE
    } spio_state_t;
    localparam int CS_LSB  = 0;
    localparam int LED_LSB = 2;
    function automatic int gpio_lsb(input int led_w);
        return led_w + 2;
    endfunction
endpackage

// File: rtl/spio_clkdiv.sv
// spio_clkdiv: half-period timer; o_tick is high on every CLK_DIV-th cycle after a restart.
// Ports: clk (system clock), rst (sync active-low reset), i_restart (zero the count on this edge),
//        o_tick (last cycle of the current half-period).
module spio_clkdiv
    import spio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);
    localparam int CW = $clog2(CLK_DIV + 1);
    logic [CW-1:0] r_cnt;
    assign o_tick = r_cnt == CW'(CLK_DIV - 1);
    always_ff @(posedge clk) begin
        if (!rst || i_restart || o_tick) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/spio_chain.sv
// spio_chain: latches a CPU word into counter-select / LED / GPIO fields and refreshes an
//             external 74HC595-style chain with the LED image in the background.
// Ports: clk, rst (sync active-low); Start (refresh request), EN + P_Data (field write);
//        counter_set / LED_out / GPIOf0 (latched fields); led_clk / led_sout / led_clrn /
//        LED_PEN (chain interface); busy (refresh running), done (one-cycle completion pulse).
module spio_chain
    import spio_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LED_W     = 16,
    parameter int CHAIN_W   = 16,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1,
    parameter int INV       = 0,
    parameter int AUTO      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Start,
    input  logic                      EN,
    input  logic [DATA_W-1:0]         P_Data,
    output logic [1:0]                counter_set,
    output logic [LED_W-1:0]          LED_out,
    output logic [DATA_W-LED_W-3:0]   GPIOf0,
    output logic                      led_clk,
    output logic                      led_sout,
    output logic                      led_clrn,
    output logic                      LED_PEN,
    output logic                      busy,
    output logic                      done
);
    localparam int GW = DATA_W - LED_W - 2;
    localparam int BW = $clog2(CHAIN_W + 1);
    spio_state_t        r_state, w_next;
    logic [1:0]         r_cs;
    logic [LED_W-1:0]   r_led;
    logic [GW-1:0]      r_gpio;
    logic [CHAIN_W-1:0] r_shreg;
    logic [CHAIN_W-1:0] w_snap;
    logic [BW-1:0]      r_bits;
    logic               r_pend, r_cleared, r_clrn, r_sout, r_ph;
    logic               w_req, w_tick;
    function automatic logic first_bit(input logic [CHAIN_W-1:0] v);
        return (MSB_FIRST != 0) ? v[CHAIN_W-1] : v[0];
    endfunction
    function automatic logic [CHAIN_W-1:0] advance(input logic [CHAIN_W-1:0] v);
        return (MSB_FIRST != 0) ? v << 1 : v >> 1;
    endfunction
    assign w_req       = Start | ((AUTO != 0) & EN);
    assign w_snap      = r_led[CHAIN_W-1:0] ^ {CHAIN_W{INV != 0}};
    assign counter_set = r_cs;
    assign LED_out     = r_led;
    assign GPIOf0      = r_gpio;
    assign led_clrn    = r_clrn;
    assign led_sout    = r_sout;
    // Every state change starts a fresh half-period, so timed states always last CLK_DIV cycles.
    spio_clkdiv #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .rst      (rst),
        .i_restart(w_next != r_state),
        .o_tick   (w_tick)
    );
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_req) w_next = r_cleared ? ST_LOAD : ST_CLR;
            ST_CLR:   if (w_tick) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_SHIFT;
            ST_SHIFT: if (w_tick && r_ph && r_bits == BW'(1)) w_next = ST_LATCH;
            ST_LATCH: if (w_tick) w_next = ST_DONE;
            ST_DONE:  w_next = (r_pend || w_req) ? ST_LOAD : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end
    always_comb begin
        busy    = r_state != ST_IDLE;
        done    = r_state == ST_DONE;
        LED_PEN = r_state == ST_LATCH;
        led_clk = (r_state == ST_SHIFT) & r_ph;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cs      <= '0;
            r_led     <= '0;
            r_gpio    <= '0;
            r_pend    <= 1'b0;
            r_cleared <= 1'b0;
            r_clrn    <= 1'b0;
            r_sout    <= 1'b0;
            r_ph      <= 1'b0;
            r_bits    <= '0;
            r_shreg   <= '0;
        end else begin
            if (EN) begin
                r_cs   <= P_Data[CS_LSB +: 2];
                r_led  <= P_Data[LED_LSB +: LED_W];
                r_gpio <= P_Data[gpio_lsb(LED_W) +: GW];
            end
            // DONE consumes any outstanding or same-cycle request directly.
            r_pend <= (r_state == ST_DONE) ? 1'b0 : r_pend | (w_req & (r_state != ST_IDLE));
            // Registered from next state so the clear pulse lines up exactly with CLR.
            r_clrn <= w_next != ST_CLR;
            if (r_state == ST_CLR && w_tick) r_cleared <= 1'b1;
            if (r_state == ST_LOAD) begin
                r_sout  <= first_bit(w_snap);
                r_shreg <= advance(w_snap);
                r_bits  <= BW'(CHAIN_W);
                r_ph    <= 1'b0;
            end
            // r_ph=0 is the low half of a bit, r_ph=1 the high half; data moves at high->low.
            if (r_state == ST_SHIFT && w_tick) begin
                r_ph <= ~r_ph;
                if (r_ph) begin
                    r_bits <= r_bits - 1'b1;
                    if (r_bits != BW'(1)) begin
                        r_sout  <= first_bit(r_shreg);
                        r_shreg <= advance(r_shreg);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spio_chain.sv
// tb_spio_chain: scoreboard bench for spio_chain; three instances cover default, INV/LSB-first
//                and CLK_DIV=1/CHAIN_W=4/AUTO=0 configurations.
module tb_spio_chain;
    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          cyc;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  start = '0;
    logic [2:0]  en = '0;
    logic [31:0] p_data [3];
    wire  [1:0]  cs [3];
    wire  [15:0] led_out [3];
    wire  [13:0] gpio [3];
    wire  [2:0]  led_clk, led_sout, led_clrn, led_pen, busy, done;
    exp_t        sbq [3][$];
    exp_t        mon_e;
    int          total = 0, bad = 0, cyc = 0, t0 = 0, ts = 0;
    int          nrise [3], npen [3], last_rise [3];
    logic [15:0] obs [3];
    logic [2:0]  pclk = '0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        spio_chain #(
            .CLK_DIV  (g == 2 ? 1 : 4),
            .CHAIN_W  (g == 2 ? 4 : 16),
            .MSB_FIRST(g == 1 ? 0 : 1),
            .INV      (g == 1 ? 1 : 0),
            .AUTO     (g == 2 ? 0 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .Start      (start[g]),
            .EN         (en[g]),
            .P_Data     (p_data[g]),
            .counter_set(cs[g]),
            .LED_out    (led_out[g]),
            .GPIOf0     (gpio[g]),
            .led_clk    (led_clk[g]),
            .led_sout   (led_sout[g]),
            .led_clrn   (led_clrn[g]),
            .LED_PEN    (led_pen[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );
    end
    function automatic int div_of(input int d);
        return d == 2 ? 1 : 4;
    endfunction
    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask
    task automatic pulse(input int d, input logic s, input logic e, input logic [31:0] v);
        @(posedge clk); #1;
        start[d]  = s;
        en[d]     = e;
        p_data[d] = v;
        t0        = cyc + 1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        en[d]    = 1'b0;
    endtask
    task automatic expect_refresh(input int d, input logic [15:0] bits, input int nbits, input int c);
        exp_t e;
        e.bits  = bits;
        e.nbits = nbits;
        e.cyc   = c;
        sbq[d].push_back(e);
    endtask
    task automatic drain(input int d);
        for (int i = 0; i < 600 && sbq[d].size() != 0; i++) @(posedge clk);
        if (sbq[d].size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain dut%0d: %0d refreshes outstanding, expected 0", d, sbq[d].size());
            sbq[d].delete();
        end
        repeat (2) @(posedge clk);
    endtask
    task automatic check_reset_state(input int d);
        check("rst_fields", d, {cs[d], led_out[d], gpio[d]}, 32'h0);
        check("rst_ctl", d, {led_clk[d], led_sout[d], led_clrn[d], led_pen[d], busy[d], done[d]}, 32'h0);
    endtask
    // Monitor: collects chain bits on led_clk rising edges and scores each refresh at done.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                nrise[d] = 0;
                npen[d]  = 0;
                obs[d]   = '0;
                pclk[d]  = 1'b0;
            end else begin
                if (led_clk[d] && !pclk[d]) begin
                    if (nrise[d] > 0) check("clk_period", d, cyc - last_rise[d], 2 * div_of(d));
                    last_rise[d] = cyc;
                    obs[d]       = {obs[d][14:0], led_sout[d]};
                    nrise[d]++;
                end
                pclk[d] = led_clk[d];
                if (led_pen[d]) npen[d]++;
                if (done[d]) begin
                    if (sbq[d].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_done dut%0d: got done at cycle %0d expected none", d, cyc);
                    end else begin
                        mon_e = sbq[d].pop_front();
                        check("bits", d, obs[d], mon_e.bits);
                        check("nbits", d, nrise[d], mon_e.nbits);
                        check("pen_width", d, npen[d], div_of(d));
                        check("done_cycle", d, cyc, mon_e.cyc);
                    end
                    nrise[d] = 0;
                    npen[d]  = 0;
                    obs[d]   = '0;
                end
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end
    initial begin
        for (int d = 0; d < 3; d++) p_data[d] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check_reset_state(d);
        rst = 1'b1;
        pulse(0, 1'b0, 1'b1, 32'hABCD_1235);
        check("cs", 0, cs[0], 2'b01);
        check("led", 0, led_out[0], 16'h448D);
        check("gpio", 0, gpio[0], 14'h2AF3);
        check("clrn_in_clr", 0, led_clrn[0], 1'b0);
        check("busy_auto", 0, busy[0], 1'b1);
        expect_refresh(0, 16'h448D, 16, t0 + 137);
        drain(0);
        pulse(0, 1'b1, 1'b1, 32'h0002_0004);
        check("led", 0, led_out[0], 16'h8001);
        check("clrn_no_clr", 0, led_clrn[0], 1'b1);
        expect_refresh(0, 16'h8001, 16, t0 + 133);
        drain(0);
        pulse(0, 1'b1, 1'b0, 32'h0);
        ts = t0;
        repeat (40) @(posedge clk);
        pulse(0, 1'b0, 1'b1, 32'h0000_0004);
        check("led_mid", 0, led_out[0], 16'h0001);
        check("busy_mid", 0, busy[0], 1'b1);
        expect_refresh(0, 16'h8001, 16, ts + 133);
        expect_refresh(0, 16'h0001, 16, ts + 267);
        drain(0);
        pulse(0, 1'b1, 1'b0, 32'h0);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_pen", 0, led_pen[0], 1'b0);
        end
        for (int d = 0; d < 3; d++) check_reset_state(d);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) check("busy_after_rst", d, busy[d], 1'b0);
        pulse(0, 1'b1, 1'b1, 32'h0002_0004);
        expect_refresh(0, 16'h8001, 16, t0 + 137);
        drain(0);
        pulse(1, 1'b0, 1'b1, 32'h0000_003C);
        check("led", 1, led_out[1], 16'h000F);
        expect_refresh(1, 16'h0FFF, 16, t0 + 137);
        drain(1);
        pulse(2, 1'b0, 1'b1, 32'h0000_0028);
        check("led", 2, led_out[2], 16'h000A);
        check("no_auto", 2, busy[2], 1'b0);
        pulse(2, 1'b1, 1'b0, 32'h0);
        expect_refresh(2, 16'h000A, 4, t0 + 11);
        drain(2);
        pulse(2, 1'b1, 1'b0, 32'h0);
        expect_refresh(2, 16'h000A, 4, t0 + 10);
        drain(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
